board_mem_ctrl: RTL and testbench
=================================

// Module: board_mem_ctrl
// PURPOSE
//  Connect-4 board store and read responder on the far end of the VGA row-fetch port (addr/rden -> ready/data).
//  Holds a 6x7 board of 2-bit cells and returns one packed 14-bit row per request.
//  Services piece drops from the game FSM using gravity, plus a board clear.
//  Cell codes: 0 empty, 1 player1, 2 player2, 3 reserved.
// PARAMETERS
//  ROWS      6   board rows; row 0 is the top display row
//  COLS      7   board columns; column 0 is the leftmost
//  CELL_W    2   bits per cell
//  ADDR_W    6   read address width
//  READ_LAT  1   cycles from read accept to ready; must be >= 1
//  Derived localparam DATA_W = COLS*CELL_W = 14.
// PORTS
//  clk          in   1        clock, 25 MHz
//  rst          in   1        reset, synchronous, active-low
//  rden         in   1        read request; held high until ready is seen
//  addr         in   ADDR_W   row base address = row*COLS (0,7,14,21,28,35)
//  ready        out  1        one-cycle pulse; data is valid in the same cycle
//  data         out  DATA_W   data[2c+1:2c] = cell(row, c)
//  drop_req     in   1        drop request; level, held until drop_ack
//  drop_col     in   3        target column
//  drop_player  in   2        piece code; only 1 or 2 are legal
//  drop_ack     out  1        one-cycle pulse that completes a drop
//  drop_ok      out  1        valid with drop_ack; 1 = piece placed
//  drop_row     out  3        valid with drop_ack; row where the piece landed
//  clr          in   1        clear request; a single-cycle pulse is enough
//  clr_done     out  1        one-cycle pulse after the board is zeroed
//  addr_err     out  1        sticky; set on an illegal read address
// BEHAVIOUR
//  Reset (rst=0 at a clk edge):
//   - All cells are set to 0 and state goes to IDLE.
//   - ready, data, drop_ack, drop_ok, drop_row, clr_done and addr_err all go to 0. clr_pend is cleared.
//   - Any in-flight transaction is abandoned and no ack or ready is issued for it.
//  FSM states: IDLE, RD_WAIT, RD_REL, DROP, DROP_REL, CLEAR.
//  IDLE: priority is clr_pend > rden > drop_req.
//  clr_pend is set by clr in any state and is serviced only from IDLE.
//  Read path:
//   - IDLE with rden=1 at edge N: latch addr and go to RD_WAIT.
//   - At edge N+READ_LAT, data is registered from the snapshot of the latched row; ready=1 for exactly one cycle.
//   - Then RD_REL. Stay there while rden=1. Return to IDLE on the first cycle rden=0.
//   - This blocks double-serving, because the requester drops rden one cycle after it sees ready.
//   - data holds its last value until the next ready.
//  Illegal address (not a multiple of COLS, or > (ROWS-1)*COLS):
//   - Respond normally with data=0 and set addr_err.
//   - addr_err clears only on rst.
//  Drop path:
//   - IDLE with drop_req=1 goes to DROP.
//   - Find the highest-numbered empty row r in drop_col.
//   - If one exists, drop_col<COLS and drop_player is 1 or 2: write the cell, drop_ok=1, drop_row=r.
//   - Otherwise: board unchanged, drop_ok=0, drop_row=0.
//   - drop_ack pulses at the DROP cycle edge, then DROP_REL until drop_req=0, then IDLE.
//  Clear: CLEAR takes one cycle. It zeroes all cells, clears clr_pend, pulses clr_done, then returns to IDLE.
//  Simultaneous events:
//   - A read that has been accepted always returns the board state at accept time, even if clr arrives mid-read.
//   - A drop_req arriving during a read waits, because the request is a held level.
//   - The drop path (DROP) and the write to a cell never occur in the same cycle as a read snapshot.
// CONFIGURATION
//  BOARD_MEM_OCCUPANCY_EN defined:
//   - Adds output pieces [5:0], the count of non-empty cells (0..42), and output board_full = (pieces==ROWS*COLS).
//   - pieces increments on every drop_ok=1, resets to 0 on clr or rst, and never exceeds 42.
//  Undefined: neither port exists and there is no counter logic.
// STRUCTURE
//  Package board_pkg holds ROWS, COLS, CELL_W, the CELL_EMPTY/CELL_P1/CELL_P2 codes and the state enum.
//  Sub-module board_col_scan: a combinational priority encoder.
//   - Input: a column's ROWS cells. Outputs: found and the lowest empty row.
//   - Instantiated once, driven by drop_col.
//  Cell storage is a flat register array; no RAM inference is required.
// TESTING
//  1. After reset, read addr=35 -> ready exactly READ_LAT cycles after accept, data=14'h0000, addr_err=0.
//  2. Drop col 3, player 1 -> drop_ok=1, drop_row=5. Read addr=35 -> data=14'h0040.
//  3. Seven drops into col 0 -> the first 6 acks are ok with rows 5..0; the 7th gives drop_ok=0 and row 0 is unchanged.
//  4. Hold rden high for 5 cycles after ready -> only one ready pulse. Read addr=8 -> data=0 and addr_err=1.
//  5. Set drop_req during RD_WAIT -> drop_ack comes only after RD_REL->IDLE; exactly one piece is written.
//  6. clr pulse mid-read -> the read returns the pre-clear row, then clr_done; reading every row returns 0. Drive rst=0 mid-DROP -> no drop_ack.

Source files
------------

// File: rtl/board_pkg.sv
// Shared board geometry, cell codes and controller state encoding for board_mem_ctrl.
package board_pkg;

  localparam int ROWS   = 6;
  localparam int COLS   = 7;
  localparam int CELL_W = 2;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 3;
  localparam int DATA_W = COLS * CELL_W;
  localparam int CELLS  = ROWS * COLS;

  typedef logic [CELL_W-1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'd0;
  localparam cell_t CELL_P1    = 2'd1;
  localparam cell_t CELL_P2    = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_REL,
    ST_DROP,
    ST_DROP_REL,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/board_col_scan.sv
// Gravity scan of one board column: reports whether an empty cell exists and the
// highest-numbered (physically lowest) empty row, where a dropped piece lands.
module board_col_scan
  import board_pkg::*;
(
  input  logic [ROWS*CELL_W-1:0] cells,
  output logic                   found,
  output logic [ROW_W-1:0]       row
);

  always_comb begin
    found = 1'b0;
    row   = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!found && cells[r*CELL_W +: CELL_W] == CELL_EMPTY) begin
        found = 1'b1;
        row   = ROW_W'(r);
      end
    end
  end

endmodule

// File: rtl/board_mem_ctrl.sv
// Connect-4 board store: serves VGA row fetches, gravity drops and board clears.
// Optional occupancy counter (pieces, board_full) enabled by BOARD_MEM_OCCUPANCY_EN.
module board_mem_ctrl
  import board_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rden,
  input  logic [ADDR_W-1:0] addr,
  output logic              ready,
  output logic [DATA_W-1:0] data,
  input  logic              drop_req,
  input  logic [COL_W-1:0]  drop_col,
  input  logic [CELL_W-1:0] drop_player,
  output logic              drop_ack,
  output logic              drop_ok,
  output logic [ROW_W-1:0]  drop_row,
  input  logic              clr,
  output logic              clr_done,
  output logic              addr_err
`ifdef BOARD_MEM_OCCUPANCY_EN
  ,
  output logic [5:0]        pieces,
  output logic              board_full
`endif
);

  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_t            state, state_nxt;
  cell_t             cells [ROWS][COLS];
  logic [ADDR_W-1:0] rd_addr;
  logic [LAT_W-1:0]  lat_cnt;
  logic              clr_pend;
  logic              rd_accept, rd_emit, drop_do, clear_do;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_row_data;
  logic [ROWS*CELL_W-1:0] col_cells;
  logic              scan_found;
  logic [ROW_W-1:0]  scan_row;
  logic              drop_legal;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    rd_accept = 1'b0;
    rd_emit   = 1'b0;
    drop_do   = 1'b0;
    clear_do  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (clr_pend) begin
          state_nxt = ST_CLEAR;
        end else if (rden) begin
          rd_accept = 1'b1;
          state_nxt = ST_RD_WAIT;
        end else if (drop_req) begin
          state_nxt = ST_DROP;
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt == '0) begin
          rd_emit   = 1'b1;
          state_nxt = ST_RD_REL;
        end
      end
      ST_RD_REL:   if (!rden) state_nxt = ST_IDLE;
      ST_DROP: begin
        drop_do   = 1'b1;
        state_nxt = ST_DROP_REL;
      end
      ST_DROP_REL: if (!drop_req) state_nxt = ST_IDLE;
      ST_CLEAR: begin
        clear_do  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The board cannot change while a read is in flight, so the row seen at emit equals the row at accept.
  always_comb begin
    rd_hit      = 1'b0;
    rd_row_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rd_addr == ADDR_W'(r * COLS)) begin
        rd_hit = 1'b1;
        for (int c = 0; c < COLS; c++) rd_row_data[c*CELL_W +: CELL_W] = cells[r][c];
      end
    end
  end

  // An out-of-range column presents as completely full, so the scan reports no landing row.
  always_comb begin
    col_cells = '1;
    for (int c = 0; c < COLS; c++) begin
      if (drop_col == COL_W'(c)) begin
        for (int r = 0; r < ROWS; r++) col_cells[r*CELL_W +: CELL_W] = cells[r][c];
      end
    end
  end

  board_col_scan u_col_scan (
    .cells (col_cells),
    .found (scan_found),
    .row   (scan_row)
  );

  assign drop_legal = scan_found && (drop_player == CELL_P1 || drop_player == CELL_P2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready    <= 1'b0;
      data     <= '0;
      drop_ack <= 1'b0;
      drop_ok  <= 1'b0;
      drop_row <= '0;
      clr_done <= 1'b0;
      addr_err <= 1'b0;
      clr_pend <= 1'b0;
      rd_addr  <= '0;
      lat_cnt  <= '0;
      // NOTE: the cell array is a plain register file, so it is reset like any other state.
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) cells[r][c] <= CELL_EMPTY;
    end else begin
      ready    <= 1'b0;
      drop_ack <= 1'b0;
      clr_done <= 1'b0;

      if (clr)           clr_pend <= 1'b1;
      else if (clear_do) clr_pend <= 1'b0;

      if (rd_accept) begin
        rd_addr <= addr;
        lat_cnt <= LAT_W'(READ_LAT - 1);
      end else if (state == ST_RD_WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end

      if (rd_emit) begin
        ready <= 1'b1;
        data  <= rd_row_data;
        if (!rd_hit) addr_err <= 1'b1;
      end

      if (drop_do) begin
        drop_ack <= 1'b1;
        drop_ok  <= drop_legal;
        drop_row <= drop_legal ? scan_row : '0;
      end

      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (clear_do)
            cells[r][c] <= CELL_EMPTY;
          else if (drop_do && drop_legal && scan_row == ROW_W'(r) && drop_col == COL_W'(c))
            cells[r][c] <= drop_player;
        end
      end

      if (clear_do) clr_done <= 1'b1;
    end
  end

`ifdef BOARD_MEM_OCCUPANCY_EN
  always_ff @(posedge clk) begin
    if (!rst || clear_do)
      pieces <= '0;
    else if (drop_do && drop_legal && pieces != 6'(CELLS))
      pieces <= pieces + 6'd1;
  end

  assign board_full = (pieces == 6'(CELLS));
`endif

endmodule

// File: tb/tb_board_mem_ctrl.sv
// Scoreboard bench for board_mem_ctrl: expectations are queued at stimulus time and
// compared by a monitor when ready / drop_ack pulse.
module tb_board_mem_ctrl;

  localparam int N_ROWS   = 6;
  localparam int N_COLS   = 7;
  localparam int READ_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rden;
  logic [5:0]  addr;
  logic        ready;
  logic [13:0] data;
  logic        drop_req;
  logic [2:0]  drop_col;
  logic [1:0]  drop_player;
  logic        drop_ack;
  logic        drop_ok;
  logic [2:0]  drop_row;
  logic        clr;
  logic        clr_done;
  logic        addr_err;
`ifdef BOARD_MEM_OCCUPANCY_EN
  logic [5:0]  pieces;
  logic        board_full;
`endif

  board_mem_ctrl #(.ADDR_W(6), .READ_LAT(READ_LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .rden        (rden),
    .addr        (addr),
    .ready       (ready),
    .data        (data),
    .drop_req    (drop_req),
    .drop_col    (drop_col),
    .drop_player (drop_player),
    .drop_ack    (drop_ack),
    .drop_ok     (drop_ok),
    .drop_row    (drop_row),
    .clr         (clr),
    .clr_done    (clr_done),
    .addr_err    (addr_err)
`ifdef BOARD_MEM_OCCUPANCY_EN
    ,
    .pieces      (pieces),
    .board_full  (board_full)
`endif
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [13:0] data;
    logic        err;
    string       tag;
  } rd_exp_t;

  typedef struct {
    logic       ok;
    logic [2:0] row;
    string      tag;
  } dr_exp_t;

  rd_exp_t rd_q[$];
  dr_exp_t dr_q[$];

  int board [N_ROWS][N_COLS];
  bit err_model;
  int pieces_model;

  int n_vec  = 0;
  int n_miss = 0;
  int ready_cnt = 0;
  int ack_cnt   = 0;
  int clr_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready) begin
      ready_cnt++;
      if (rd_q.size() == 0) begin
        check("ready_unexpected", 32'd1, 32'd0);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check({e.tag, "_data"}, 32'(data), 32'(e.data));
        check({e.tag, "_err"}, 32'(addr_err), 32'(e.err));
      end
    end
    if (drop_ack) begin
      ack_cnt++;
      if (dr_q.size() == 0) begin
        check("ack_unexpected", 32'd1, 32'd0);
      end else begin
        dr_exp_t d;
        d = dr_q.pop_front();
        check({d.tag, "_ok"}, 32'(drop_ok), 32'(d.ok));
        check({d.tag, "_row"}, 32'(drop_row), 32'(d.row));
      end
    end
    if (clr_done) clr_cnt++;
  end

  function automatic bit legal_addr(input int a);
    return (a % N_COLS == 0) && (a <= (N_ROWS - 1) * N_COLS);
  endfunction

  function automatic logic [13:0] model_row(input int a);
    logic [13:0] v;
    v = '0;
    if (legal_addr(a))
      for (int c = 0; c < N_COLS; c++) v[2*c +: 2] = 2'(board[a / N_COLS][c]);
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < N_ROWS; r++)
      for (int c = 0; c < N_COLS; c++) board[r][c] = 0;
    pieces_model = 0;
  endtask

  task automatic push_read(input int a, input string tag);
    rd_exp_t e;
    e.data = model_row(a);
    if (!legal_addr(a)) err_model = 1'b1;
    e.err = err_model;
    e.tag = tag;
    rd_q.push_back(e);
  endtask

  task automatic push_drop(input int col, input int player, input string tag);
    dr_exp_t e;
    bit done;
    e.ok  = 1'b0;
    e.row = '0;
    e.tag = tag;
    done  = 1'b0;
    if (col < N_COLS && (player == 1 || player == 2)) begin
      for (int r = N_ROWS - 1; r >= 0; r--) begin
        if (!done && board[r][col] == 0) begin
          done = 1'b1;
          e.ok = 1'b1;
          e.row = 3'(r);
          board[r][col] = player;
          pieces_model++;
        end
      end
    end
    dr_q.push_back(e);
  endtask

  task automatic wait_ready(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!ready && cycles < 50);
    if (!ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_ack(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!drop_ack && cycles < 50);
    if (!drop_ack) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_read(input int a, input int hold, input string tag, output int lat);
    int start;
    push_read(a, tag);
    start = ready_cnt;
    addr  = 6'(a);
    rden  = 1'b1;
    wait_ready(tag, lat);
    repeat (hold) @(negedge clk);
    rden = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_npulse"}, 32'(ready_cnt - start), 32'd1);
  endtask

  task automatic do_drop(input int col, input int player, input string tag);
    int cyc;
    push_drop(col, player, tag);
    drop_col    = 3'(col);
    drop_player = 2'(player);
    drop_req    = 1'b1;
    wait_ack(tag, cyc);
    drop_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, cyc, a0, c0, r0;
    rst = 1'b0; rden = 1'b0; addr = '0; drop_req = 1'b0;
    drop_col = '0; drop_player = '0; clr = 1'b0;
    err_model = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);

    check("rst_ready",    32'(ready),    32'd0);
    check("rst_data",     32'(data),     32'd0);
    check("rst_drop_ack", 32'(drop_ack), 32'd0);
    check("rst_drop_ok",  32'(drop_ok),  32'd0);
    check("rst_drop_row", 32'(drop_row), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Read latency from an idle controller, empty board.
    do_read(35, 0, "t1", lat);
    check("t1_lat", lat, READ_LAT + 1);

    do_drop(3, 1, "t2_drop");
    do_read(35, 0, "t2_rd", lat);
    check("t2_const", 32'(data), 32'h0040);

    // Fill column 0 and overflow it.
    for (int i = 0; i < 7; i++) do_drop(0, (i % 2) + 1, $sformatf("t3_d%0d", i));
    do_read(0, 0, "t3_row0", lat);
    check("t3_const", 32'(data), 32'h0002);
    do_drop(7, 1, "bad_col");
    do_drop(2, 3, "bad_player3");
    do_drop(2, 0, "bad_player0");

    do_read(35, 5, "t4_hold", lat);
    do_read(8, 0, "t4_bad8", lat);
    check("t4_err_sticky", 32'(addr_err), 32'd1);
    do_read(42, 0, "t4_bad42", lat);
    do_read(7, 0, "t4_row1", lat);

    // Drop request raised while a read is in RD_WAIT.
    push_read(35, "t5_rd");
    push_drop(4, 2, "t5_drop");
    a0 = ack_cnt;
    r0 = ready_cnt;
    addr = 6'd35;
    rden = 1'b1;
    @(negedge clk);
    drop_col = 3'd4; drop_player = 2'd2; drop_req = 1'b1;
    wait_ready("t5_rd", lat);
    check("t5_no_ack_in_read", 32'(ack_cnt - a0), 32'd0);
    rden = 1'b0;
    wait_ack("t5_drop", cyc);
    check("t5_ack_delay", cyc, 3);
    drop_req = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_one_ack", 32'(ack_cnt - a0), 32'd1);
    check("t5_one_ready", 32'(ready_cnt - r0), 32'd1);
    do_read(35, 0, "t5_row5", lat);
    do_read(28, 0, "t5_row4", lat);

    // Clear pulse arriving mid-read.
    push_read(35, "t6_rd");
    c0 = clr_cnt;
    addr = 6'd35;
    rden = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    wait_ready("t6_rd", lat);
    clr  = 1'b0;
    rden = 1'b0;
    check("t6_no_clr_yet", 32'(clr_cnt - c0), 32'd0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!clr_done && cyc < 50);
    check("t6_clr_done", 32'(clr_done), 32'd1);
    @(negedge clk);
    check("t6_clr_once", 32'(clr_cnt - c0), 32'd1);
    clear_model();
    for (int r = 0; r < N_ROWS; r++) do_read(r * N_COLS, 0, $sformatf("t6_r%0d", r), lat);

    // Reset while in DROP abandons the drop.
    do_drop(5, 1, "pre_rst");
    a0 = ack_cnt;
    drop_col = 3'd1; drop_player = 2'd1; drop_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_rst_no_ack", 32'(ack_cnt - a0), 32'd0);
    drop_req = 1'b0;
    rst = 1'b1;
    clear_model();
    err_model = 1'b0;
    @(negedge clk);
    check("t6_rst_err", 32'(addr_err), 32'd0);
    do_read(35, 0, "t6_post_rst", lat);
    do_drop(1, 2, "t6_post_drop");
    do_read(35, 0, "t6_post_rd", lat);

`ifdef BOARD_MEM_OCCUPANCY_EN
    check("occ_pieces", 32'(pieces), 32'(pieces_model));
    check("occ_full", 32'(board_full), 32'(pieces_model == N_ROWS * N_COLS));
`endif

    check("rd_q_drained", rd_q.size(), 0);
    check("dr_q_drained", dr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
